// File: rtl/accel_bus_pkg.sv
// Shared definitions for the accelerator register bus master.
// Holds the accelerator register map, the opcode constants the master must
// recognise, and the master's FSM state encoding.
package accel_bus_pkg;

    // Accelerator register map
    localparam logic [3:0] ADDR_A      = 4'h0;
    localparam logic [3:0] ADDR_B      = 4'h1;
    localparam logic [3:0] ADDR_OP     = 4'h4;
    localparam logic [3:0] ADDR_RES_LO = 4'h5;
    localparam logic [3:0] ADDR_RES_HI = 4'h6;
    localparam logic [3:0] ADDR_START  = 4'h7;

    // Value written to START to kick the accelerator
    localparam logic [7:0] START_CMD   = 8'h01;

    // Opcodes understood by the accelerator; anything above OP_OR is
    // passed through and the accelerator reports 0 for it.
    localparam logic [3:0] OP_ADD      = 4'h0;
    localparam logic [3:0] OP_SUB      = 4'h1;
    localparam logic [3:0] OP_MUL      = 4'h2;
    localparam logic [3:0] OP_DIV      = 4'h3;
    localparam logic [3:0] OP_AND      = 4'h4;
    localparam logic [3:0] OP_XOR      = 4'h5;
    localparam logic [3:0] OP_OR       = 4'h6;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_A,
        S_WR_B,
        S_WR_OP,
        S_WR_START,
        S_SETTLE,
        S_RD_LO,
        S_RD_HI,
        S_RESP
    } state_t;

endpackage

// File: rtl/accel_bus_master.sv
// Drives one accelerator job at a time over a simple register bus:
// writes A, B, OP and START, waits SETTLE_CYCLES, reads the 16-bit result
// back in two byte reads, then presents it on a valid/ready response channel.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   job_valid/job_ready             job request handshake
//   job_a, job_b, job_op            job operands and opcode
//   rsp_valid/rsp_ready             response handshake
//   rsp_result, rsp_div0            16-bit result, divide-by-zero flag
//   bus_address, bus_data_write,    register bus initiator; reads are
//   bus_wdata, bus_rdata            combinational (rdata valid same cycle)
module accel_bus_master
    import accel_bus_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [7:0]  job_a,
    input  logic [7:0]  job_b,
    input  logic [3:0]  job_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_div0,
    output logic [3:0]  bus_address,
    output logic        bus_data_write,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata
);

    // Counter preload: SETTLE lasts SETTLE_LAST+1 cycles.
    localparam logic [3:0] SETTLE_LAST =
        (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

    state_t      state;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [3:0]  op_q;
    logic [15:0] result;
    logic [3:0]  settle_cnt;

    // Divide by zero is decided purely from the latched job.
    logic        div0;
    assign div0 = (op_q == OP_DIV) && (b_q == 8'h00);

    assign rsp_result = result;

    // All outputs are registered and computed for the state being entered,
    // so every bus cycle is glitch-free and lines up exactly with its state.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge (synchronous), so it lives
        // inside the clocked block rather than in the sensitivity list.
        if (!rst_n) begin
            state          <= S_IDLE;
            a_q            <= '0;
            b_q            <= '0;
            op_q           <= '0;
            result         <= '0;
            settle_cnt     <= '0;
            rsp_div0       <= 1'b0;
            job_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            bus_address    <= ADDR_A;
            bus_data_write <= 1'b0;
            bus_wdata      <= 8'h00;
        end else begin
            // NOTE: non-blocking defaults followed by per-state overrides;
            // the last assignment in program order wins at the clock edge.
            bus_address    <= ADDR_A;
            bus_data_write <= 1'b0;
            bus_wdata      <= 8'h00;

            unique case (state)
                S_IDLE: begin
                    if (job_valid) begin
                        a_q            <= job_a;
                        b_q            <= job_b;
                        op_q           <= job_op;
                        rsp_div0       <= 1'b0;
                        job_ready      <= 1'b0;
                        state          <= S_WR_A;
                        bus_address    <= ADDR_A;
                        bus_data_write <= 1'b1;
                        bus_wdata      <= job_a;
                    end
                end
                S_WR_A: begin
                    state          <= S_WR_B;
                    bus_address    <= ADDR_B;
                    bus_data_write <= 1'b1;
                    bus_wdata      <= b_q;
                end
                S_WR_B: begin
                    state          <= S_WR_OP;
                    bus_address    <= ADDR_OP;
                    bus_data_write <= 1'b1;
                    bus_wdata      <= {4'h0, op_q};
                end
                S_WR_OP: begin
                    state          <= S_WR_START;
                    bus_address    <= ADDR_START;
                    bus_data_write <= 1'b1;
                    bus_wdata      <= START_CMD;
                end
                S_WR_START: begin
                    if (SETTLE_CYCLES == 0) begin
                        state       <= S_RD_LO;
                        bus_address <= ADDR_RES_LO;
                    end else begin
                        state       <= S_SETTLE;
                        settle_cnt  <= SETTLE_LAST;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        state       <= S_RD_LO;
                        bus_address <= ADDR_RES_LO;
                    end else begin
                        settle_cnt  <= settle_cnt - 4'd1;
                    end
                end
                S_RD_LO: begin
                    result[7:0] <= div0 ? 8'h00 : bus_rdata;
                    state       <= S_RD_HI;
                    bus_address <= ADDR_RES_HI;
                end
                S_RD_HI: begin
                    result[15:8] <= div0 ? 8'h00 : bus_rdata;
                    rsp_div0     <= div0;
                    rsp_valid    <= 1'b1;
                    state        <= S_RESP;
                end
                S_RESP: begin
                    // result and rsp_div0 are untouched here, so they hold
                    // for as long as the consumer stalls.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        job_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    job_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accel_bus_master.sv
// Self-checking bench for accel_bus_master. Two instances are built: unit 0
// with SETTLE_CYCLES=1 and unit 1 with SETTLE_CYCLES=0. Each has its own
// behavioural accelerator (registers plus combinational result read-back).
// Cycle counting: the cycle in which the job handshake is sampled is cycle 0;
// RESP must then be observed in cycle 7+SETTLE_CYCLES.
module tb_accel_bus_master;

    logic        clk;
    logic        rst_n;
    logic        job_valid      [2];
    logic        job_ready      [2];
    logic [7:0]  job_a          [2];
    logic [7:0]  job_b          [2];
    logic [3:0]  job_op         [2];
    logic        rsp_valid      [2];
    logic        rsp_ready      [2];
    logic [15:0] rsp_result     [2];
    logic        rsp_div0       [2];
    logic [3:0]  bus_address    [2];
    logic        bus_data_write [2];
    logic [7:0]  bus_wdata      [2];
    logic [7:0]  bus_rdata      [2];

    // Accelerator register state per unit
    logic [7:0]  acc_a  [2];
    logic [7:0]  acc_b  [2];
    logic [3:0]  acc_op [2];

    // Write log: {unit, address, data}
    logic [12:0] wlog [$];

    int n_checks = 0;
    int n_errors = 0;

    accel_bus_master #(.SETTLE_CYCLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid[0]), .job_ready(job_ready[0]),
        .job_a(job_a[0]), .job_b(job_b[0]), .job_op(job_op[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_result(rsp_result[0]), .rsp_div0(rsp_div0[0]),
        .bus_address(bus_address[0]), .bus_data_write(bus_data_write[0]),
        .bus_wdata(bus_wdata[0]), .bus_rdata(bus_rdata[0])
    );

    accel_bus_master #(.SETTLE_CYCLES(0)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid[1]), .job_ready(job_ready[1]),
        .job_a(job_a[1]), .job_b(job_b[1]), .job_op(job_op[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_result(rsp_result[1]), .rsp_div0(rsp_div0[1]),
        .bus_address(bus_address[1]), .bus_data_write(bus_data_write[1]),
        .bus_wdata(bus_wdata[1]), .bus_rdata(bus_rdata[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural accelerator: divide by zero deliberately returns 0xFFFF so
    // the master's forcing of the result to zero is visible.
    function automatic logic [15:0] acc_calc(input logic [7:0] a, input logic [7:0] b,
                                             input logic [3:0] op);
        case (op)
            4'h0:    return 16'(a) + 16'(b);
            4'h1:    return 16'(a) - 16'(b);
            4'h2:    return 16'(a) * 16'(b);
            4'h3:    return (b == 8'h00) ? 16'hFFFF : 16'(a / b);
            4'h4:    return {8'h00, a & b};
            4'h5:    return {8'h00, a ^ b};
            4'h6:    return {8'h00, a | b};
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [7:0] acc_read(input logic [3:0] addr, input logic [15:0] res);
        if (addr == 4'h5) return res[7:0];
        if (addr == 4'h6) return res[15:8];
        return 8'h00;
    endfunction

    assign bus_rdata[0] = acc_read(bus_address[0], acc_calc(acc_a[0], acc_b[0], acc_op[0]));
    assign bus_rdata[1] = acc_read(bus_address[1], acc_calc(acc_a[1], acc_b[1], acc_op[1]));

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (bus_data_write[u]) begin
                wlog.push_back({u[0], bus_address[u], bus_wdata[u]});
                case (bus_address[u])
                    4'h0:    acc_a[u]  <= bus_wdata[u];
                    4'h1:    acc_b[u]  <= bus_wdata[u];
                    4'h4:    acc_op[u] <= bus_wdata[u][3:0];
                    default: ;
                endcase
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input int u, input string tag);
        check({tag, "_job_ready"},  32'(job_ready[u]),      32'h1);
        check({tag, "_rsp_valid"},  32'(rsp_valid[u]),      32'h0);
        check({tag, "_rsp_result"}, 32'(rsp_result[u]),     32'h0);
        check({tag, "_rsp_div0"},   32'(rsp_div0[u]),       32'h0);
        check({tag, "_bus_addr"},   32'(bus_address[u]),    32'h0);
        check({tag, "_bus_we"},     32'(bus_data_write[u]), 32'h0);
        check({tag, "_bus_wdata"},  32'(bus_wdata[u]),      32'h0);
    endtask

    // Presents a job and returns at the negedge of cycle 1 (WR_A).
    task automatic start_job(input int u, input logic [7:0] a, input logic [7:0] b,
                             input logic [3:0] op);
        int guard = 0;
        @(negedge clk);
        job_a[u] = a; job_b[u] = b; job_op[u] = op; job_valid[u] = 1'b1;
        while (!job_ready[u] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("job_ready_at_accept", 32'(job_ready[u]), 32'h1);
        wlog.delete();
        @(negedge clk);
        job_valid[u] = 1'b0;
        check("job_ready_low_busy", 32'(job_ready[u]), 32'h0);
    endtask

    // Waits (bounded) for rsp_valid and checks its cycle index.
    task automatic wait_rsp(input int u, input int exp_cycle);
        int n = 1;
        while (!rsp_valid[u] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rsp_latency", 32'(n), 32'(exp_cycle));
        check("resp_bus_addr", 32'(bus_address[u]), 32'h0);
        check("resp_bus_we", 32'(bus_data_write[u]), 32'h0);
    endtask

    task automatic finish_rsp(input int u);
        rsp_ready[u] = 1'b1;
        @(negedge clk);
        rsp_ready[u] = 1'b0;
        check("rsp_valid_drop", 32'(rsp_valid[u]), 32'h0);
        check("job_ready_back", 32'(job_ready[u]), 32'h1);
    endtask

    task automatic check_writes(input int u, input logic [7:0] a, input logic [7:0] b,
                                input logic [3:0] op);
        logic [12:0] exp [4];
        exp[0] = {u[0], 4'h0, a};
        exp[1] = {u[0], 4'h1, b};
        exp[2] = {u[0], 4'h4, 4'h0, op};
        exp[3] = {u[0], 4'h7, 8'h01};
        check("write_count", 32'(wlog.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < wlog.size()) check($sformatf("write%0d", i), 32'(wlog[i]), 32'(exp[i]));
        end
    endtask

    task automatic run_job(input int u, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] op, input logic [15:0] exp_res,
                           input logic exp_div0, input int exp_cycle);
        start_job(u, a, b, op);
        wait_rsp(u, exp_cycle);
        check("rsp_result", 32'(rsp_result[u]), 32'(exp_res));
        check("rsp_div0", 32'(rsp_div0[u]), 32'(exp_div0));
        check_writes(u, a, b, op);
        finish_rsp(u);
    endtask

    initial begin
        int n7;
        int rsp_seen;
        for (int u = 0; u < 2; u++) begin
            job_valid[u] = 1'b0; job_a[u] = 8'h00; job_b[u] = 8'h00;
            job_op[u] = 4'h0; rsp_ready[u] = 1'b0;
            acc_a[u] = 8'h00; acc_b[u] = 8'h00; acc_op[u] = 4'h0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs(0, "reset_u0");
        check_idle_outputs(1, "reset_u1");
        rst_n = 1'b1;

        // SETTLE_CYCLES=1 jobs: add, mul, sub, divide by zero, opcode above 6
        run_job(0, 8'd200, 8'd100, 4'h0, 16'h012C, 1'b0, 8);
        run_job(0, 8'd255, 8'd255, 4'h2, 16'hFE01, 1'b0, 8);
        run_job(0, 8'd5,   8'd10,  4'h1, 16'hFFFB, 1'b0, 8);
        run_job(0, 8'd7,   8'd0,   4'h3, 16'h0000, 1'b1, 8);
        run_job(0, 8'd9,   8'd9,   4'h9, 16'h0000, 1'b0, 8);

        // Response back-pressure with a stray job_valid pulse
        start_job(0, 8'd100, 8'd7, 4'h3);
        wait_rsp(0, 8);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                job_a[0] = 8'h11; job_b[0] = 8'h22; job_op[0] = 4'h0; job_valid[0] = 1'b1;
            end
            if (i == 3) job_valid[0] = 1'b0;
            check($sformatf("stall%0d_valid", i),  32'(rsp_valid[0]),  32'h1);
            check($sformatf("stall%0d_result", i), 32'(rsp_result[0]), 32'h000E);
            check($sformatf("stall%0d_ready", i),  32'(job_ready[0]),  32'h0);
            @(negedge clk);
        end
        check("stall_result_end", 32'(rsp_result[0]), 32'h000E);
        finish_rsp(0);
        repeat (3) @(negedge clk);
        check("stall_no_new_writes", 32'(wlog.size()), 32'd4);

        // Reset during WR_B
        start_job(0, 8'd1, 8'd2, 4'h0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_idle_outputs(0, "midreset");
        rsp_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid[0]) rsp_seen++;
        end
        check("midreset_no_rsp", 32'(rsp_seen), 32'd0);
        n7 = 0;
        foreach (wlog[i]) if (wlog[i][11:8] == 4'h7) n7++;
        check("midreset_no_start", 32'(n7), 32'd0);
        run_job(0, 8'd40, 8'd2, 4'h0, 16'h002A, 1'b0, 8);

        // SETTLE_CYCLES=0
        run_job(1, 8'd3, 8'd4, 4'h6, 16'h0007, 1'b0, 7);
        run_job(1, 8'd200, 8'd7, 4'h3, 16'h001C, 1'b0, 7);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/accel_bus_master.md
ACCEL_BUS_MASTER -- requirements
Module: accel_bus_master

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, range 0..15: idle cycles between the START write and the first result read.
REQ-002 SHALL have `clk`, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have `rst_n`, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have `job_valid` (input, 1), `job_ready` (output, 1), `job_a` (input, 8), `job_b` (input, 8) and `job_op` (input, 4): the job request channel.
REQ-005 SHALL have `rsp_valid` (output, 1), `rsp_ready` (input, 1), `rsp_result` (output, 16) and `rsp_div0` (output, 1): the response channel.
REQ-006 SHALL have `bus_address` (output, 4), `bus_data_write` (output, 1), `bus_wdata` (output, 8) and `bus_rdata` (input, 8): the initiator side of the accelerator register bus.

Function
REQ-007 SHALL use this accelerator register map: A=0x0, B=0x1, OP=0x4, RES_LO=0x5, RES_HI=0x6, START=0x7.
REQ-008 SHALL implement states IDLE, WR_A, WR_B, WR_OP, WR_START, SETTLE, RD_LO, RD_HI and RESP.
REQ-009 SHALL assert `job_ready` only in IDLE, and accept a job on a cycle where `job_valid` and `job_ready` are both high.
REQ-010 SHALL, on acceptance, latch `job_a`, `job_b` and `job_op`, and move to WR_A.
REQ-011 SHALL spend exactly one cycle in each WR_* state, with `bus_data_write`=1, `bus_address` set to that register and `bus_wdata` set to the latched A, B, {4'h0, op} or 8'h01.
REQ-012 SHALL, in SETTLE, hold `bus_data_write`=0 and count SETTLE_CYCLES cycles; if SETTLE_CYCLES=0, SETTLE is skipped.
REQ-013 SHALL, in RD_LO and RD_HI, drive `bus_address` to 0x5 and 0x6 respectively with `bus_data_write`=0, and capture `bus_rdata` into result[7:0] and result[15:8] at the end of that same cycle (the read path is combinational).
REQ-014 SHALL assert `rsp_valid` in RESP exactly 7+SETTLE_CYCLES cycles after the acceptance edge.
REQ-015 SHALL hold `rsp_result` and `rsp_div0` stable while `rsp_valid`=1 and `rsp_ready`=0.
REQ-016 SHALL return to IDLE on the cycle after `rsp_valid`&&`rsp_ready`; at that point `rsp_valid` falls and `job_ready` rises.
REQ-017 SHALL never accept a new job before the previous response has been consumed; there is no overlap and no pipelining.
REQ-018 SHALL set `rsp_div0`=1 when the latched op==4'h3 and B==0, and in that case force `rsp_result` to 16'h0000 while still performing all bus cycles.
REQ-019 SHALL pass opcodes above 4'h6 through unchanged; the accelerator returns 0 for them, and that value is reported.
REQ-020 SHALL, outside WR_* states, drive `bus_data_write`=0 and `bus_wdata`=8'h00; in IDLE, SETTLE and RESP it SHALL drive `bus_address`=0x0.

Reset
REQ-021 SHALL, while `rst_n`=0 at a clock edge, enter IDLE and clear the latched job, the result, the settle counter and `rsp_div0`.
REQ-022 SHALL have these output values after reset: `job_ready`=1, `rsp_valid`=0, `rsp_result`=0, `rsp_div0`=0, `bus_address`=0, `bus_data_write`=0, `bus_wdata`=0.
REQ-023 SHALL, on reset mid-transaction, abandon the transaction with no further bus write and no response; accelerator register contents are not the master's concern.

Structure
REQ-024 SHALL take the register addresses, opcode constants and the state encoding from shared package accel_bus_pkg.
REQ-025 SHALL be a single module with no sub-module; the FSM and settle counter are inline.

Verification
REQ-026 SHALL cover: SETTLE_CYCLES=1, job A=200, B=100, op=0 -> write sequence 0x0:C8, 0x1:64, 0x4:00, 0x7:01; `rsp_result`=0x012C and `rsp_valid` 8 cycles after acceptance.
REQ-027 SHALL cover: A=255, B=255, op=2 -> `rsp_result`=0xFE01; then A=5, B=10, op=1 -> `rsp_result`=0xFFFB.
REQ-028 SHALL cover: A=7, B=0, op=3 -> `rsp_div0`=1, `rsp_result`=0x0000, and all four bus writes still issued.
REQ-029 SHALL cover: `rsp_ready` held low for 5 cycles -> `rsp_valid` and `rsp_result` stable, `job_ready`=0; a `job_valid` pulse during that time is not accepted.
REQ-030 SHALL cover: `rst_n` low during WR_B -> the next cycle is IDLE with all outputs at reset values, no START write ever issued, and a following job completes normally.
REQ-031 SHALL cover: SETTLE_CYCLES=0, A=3, B=4, op=6 -> `rsp_result`=0x0007 with `rsp_valid` 7 cycles after acceptance.
